// File: rtl/ddr_axi_pkg.sv
// Shared AXI encodings, the 4 KB page constant and the write-master state type.
package ddr_axi_pkg;

  localparam logic [1:0] BURST_INCR    = 2'b01;
  localparam logic [1:0] RESP_OKAY     = 2'b00;
  localparam logic [1:0] RESP_SLVERR   = 2'b10;
  localparam logic [1:0] RESP_DECERR   = 2'b11;
  localparam logic [3:0] CACHE_DEFAULT = 4'b0011;

  localparam int unsigned BOUNDARY_4K = 4096;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/ddr_axi_len_fifo.sv
// Small synchronous FIFO carrying awlen values from the AW side to the W side.
module ddr_axi_len_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/ddr_axi_wr_master.sv
// AXI4 burst write master: splits a (start address, beat count) command into
// INCR bursts that never cross 4 KB and streams the payload onto the W channel.
module ddr_axi_wr_master
  import ddr_axi_pkg::*;
#(
  parameter int ID_WIDTH        = 4,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 512,
  parameter int AXI_ID          = 0,
  parameter int MAX_BURST       = 64,
  parameter int MAX_OUTSTANDING = 4,
  parameter int LEN_WIDTH       = 24
) (
  input  logic                    clk_ddr,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [LEN_WIDTH-1:0]    cmd_beats,
  input  logic                    s_data_valid,
  input  logic [DATA_WIDTH-1:0]   s_data,
  output logic                    s_data_ready,
  output logic                    done,
  output logic                    err,
  output logic                    busy,
  output logic [ID_WIDTH-1:0]     m_axi_awid,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]              m_axi_awlen,
  output logic [2:0]              m_axi_awsize,
  output logic [1:0]              m_axi_awburst,
  output logic [0:0]              m_axi_awlock,
  output logic [3:0]              m_axi_awcache,
  output logic [2:0]              m_axi_awprot,
  output logic [3:0]              m_axi_awqos,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wlast,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [ID_WIDTH-1:0]     m_axi_bid,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int SIZE  = $clog2(BYTES);
  localparam int OW    = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~ADDR_WIDTH'(BYTES - 1);

  state_t                  state;
  state_t                  state_nxt;
  logic                    live;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [LEN_WIDTH-1:0]    remaining;
  logic [OW-1:0]           outstanding;
  logic [OW-1:0]           outstanding_nxt;
  logic                    aw_valid;
  logic [ADDR_WIDTH-1:0]   aw_addr;
  logic [7:0]              aw_len;
  logic [8:0]              aw_blen;
  logic [8:0]              blen;
  logic [7:0]              beat_cnt;
  logic                    err_q;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [7:0]              fifo_head;
  logic                    cmd_hs;
  logic                    aw_hs;
  logic                    w_hs;
  logic                    b_hs;
  logic                    aw_issue;
  logic                    all_issued;
  logic                    unused_bid;

  // Beats in the next burst: limited by what is left, MAX_BURST and the 4 KB page.
  function automatic logic [8:0] burst_len(input logic [11:0] page_off,
                                           input logic [LEN_WIDTH-1:0] rem);
    logic [12:0] room;
    logic [31:0] n;
    room = 13'(BOUNDARY_4K) - {1'b0, page_off};
    n    = 32'(MAX_BURST);
    if (32'(room >> SIZE) < n) n = 32'(room >> SIZE);
    if (32'(rem) < n)          n = 32'(rem);
    return 9'(n);
  endfunction

  assign unused_bid = ^m_axi_bid;

  assign cmd_hs     = cmd_valid & cmd_ready;
  assign aw_hs      = aw_valid & m_axi_awready;
  assign w_hs       = m_axi_wvalid & m_axi_wready;
  assign b_hs       = m_axi_bvalid & m_axi_bready;
  assign blen       = burst_len(addr[11:0], remaining);
  assign aw_blen    = {1'b0, aw_len} + 9'd1;
  assign aw_issue   = (state == RUN) & ~aw_valid & (remaining != '0) &
                      (outstanding < OW'(MAX_OUTSTANDING)) & ~fifo_full;
  assign all_issued = (remaining == '0) & ~aw_valid & fifo_empty;

  always_comb begin
    outstanding_nxt = outstanding;
    case ({aw_hs, b_hs})
      2'b10:   outstanding_nxt = outstanding + 1'b1;
      2'b01:   outstanding_nxt = outstanding - 1'b1;
      default: outstanding_nxt = outstanding;
    endcase
  end

  // A last B that lands while still in RUN skips DRAIN so done keeps its latency.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_hs) state_nxt = (cmd_beats == '0) ? DONE : RUN;
      RUN:     if (all_issued) state_nxt = (outstanding_nxt == '0) ? DONE : DRAIN;
      DRAIN:   if (outstanding_nxt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_ddr or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk_ddr or posedge reset) begin
    if (reset) begin
      live        <= 1'b0;
      addr        <= '0;
      remaining   <= '0;
      outstanding <= '0;
      aw_valid    <= 1'b0;
      aw_addr     <= '0;
      aw_len      <= '0;
      beat_cnt    <= '0;
      err_q       <= 1'b0;
    end else begin
      live        <= 1'b1;
      outstanding <= outstanding_nxt;
      if (cmd_hs) begin
        addr      <= cmd_addr & ADDR_MASK;
        remaining <= cmd_beats;
      end else if (aw_hs) begin
        addr      <= addr + (ADDR_WIDTH'(aw_blen) << SIZE);
        remaining <= remaining - LEN_WIDTH'(aw_blen);
      end
      // AW payload is frozen while awvalid is up.
      if (aw_hs) begin
        aw_valid <= 1'b0;
      end else if (aw_issue) begin
        aw_valid <= 1'b1;
        aw_addr  <= addr;
        aw_len   <= 8'(blen - 9'd1);
      end
      if (w_hs) beat_cnt <= m_axi_wlast ? 8'd0 : beat_cnt + 8'd1;
      if (cmd_hs)                                err_q <= 1'b0;
      else if (b_hs && m_axi_bresp != RESP_OKAY) err_q <= 1'b1;
    end
  end

  // Only bursts whose AW has completed sit in the FIFO, so W can never lead AW.
  ddr_axi_len_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (8)
  ) u_len_fifo (
    .clk   (clk_ddr),
    .rst   (reset),
    .push  (aw_hs),
    .wdata (aw_len),
    .pop   (w_hs & m_axi_wlast),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign m_axi_awid    = ID_WIDTH'(AXI_ID);
  assign m_axi_awaddr  = aw_addr;
  assign m_axi_awlen   = aw_len;
  assign m_axi_awsize  = 3'(SIZE);
  assign m_axi_awburst = BURST_INCR;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = CACHE_DEFAULT;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awqos   = 4'b0000;
  assign m_axi_awvalid = aw_valid;

  assign m_axi_wdata   = s_data;
  assign m_axi_wstrb   = '1;
  assign m_axi_wvalid  = s_data_valid & ~fifo_empty;
  assign m_axi_wlast   = ~fifo_empty & (beat_cnt == fifo_head);
  assign s_data_ready  = m_axi_wready & ~fifo_empty;
  assign m_axi_bready  = (state == RUN) | (state == DRAIN);

  assign cmd_ready = live & (state == IDLE);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign err       = err_q;

endmodule

// File: tb/tb_ddr_axi_wr_master.sv
// Bench for ddr_axi_wr_master: a behavioural AXI slave with a DDR memory model
// plus a burst-splitting reference computed from the address arithmetic.
`timescale 1ns/1ps
module tb_ddr_axi_wr_master;

  localparam int DW    = 512;
  localparam int AW    = 32;
  localparam int IDW   = 4;
  localparam int LW    = 24;
  localparam int BYTES = DW / 8;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
  } burst_t;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            cmd_valid, cmd_ready;
  logic [AW-1:0]   cmd_addr;
  logic [LW-1:0]   cmd_beats;
  logic            s_data_valid, s_data_ready;
  logic [DW-1:0]   s_data;
  logic            done, err, busy;
  logic [IDW-1:0]  m_axi_awid;
  logic [AW-1:0]   m_axi_awaddr;
  logic [7:0]      m_axi_awlen;
  logic [2:0]      m_axi_awsize;
  logic [1:0]      m_axi_awburst;
  logic [0:0]      m_axi_awlock;
  logic [3:0]      m_axi_awcache;
  logic [2:0]      m_axi_awprot;
  logic [3:0]      m_axi_awqos;
  logic            m_axi_awvalid, m_axi_awready;
  logic [DW-1:0]   m_axi_wdata;
  logic [DW/8-1:0] m_axi_wstrb;
  logic            m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic [IDW-1:0]  m_axi_bid;
  logic [1:0]      m_axi_bresp;
  logic            m_axi_bvalid, m_axi_bready;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  burst_t      aw_log[$];
  burst_t      aw_q[$];
  burst_t      exp_q[$];
  logic [1:0]  b_q[$];
  logic [DW-1:0] src_q[$];
  logic [DW-1:0] exp_data[$];
  logic [DW-1:0] mem [logic [31:0]];
  logic [31:0] exp_base;
  int wbeat = 0, burst_no = 0, err_burst = -1, wlast_cnt = 0, last_b_cyc = 0;
  bit aw_always = 0, w_rand = 0, b_en = 1;

  ddr_axi_wr_master #(
    .ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .AXI_ID(0),
    .MAX_BURST(64), .MAX_OUTSTANDING(4), .LEN_WIDTH(LW)
  ) dut (
    .clk_ddr(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_beats(cmd_beats),
    .s_data_valid(s_data_valid), .s_data(s_data), .s_data_ready(s_data_ready),
    .done(done), .err(err), .busy(busy),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
    .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Slave + source model: drive on the falling edge, then record the handshakes
  // that the following rising edge will complete.
  initial begin
    m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 0;
    m_axi_bid = '0; s_data_valid = 0; s_data = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; s_data_valid = 0;
      end else begin
        m_axi_awready = aw_always ? 1'b1 : 1'($urandom_range(0, 1));
        m_axi_wready  = w_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        s_data_valid  = (src_q.size() > 0) && (w_rand ? ($urandom_range(0, 1) == 1) : 1'b1);
        s_data        = (src_q.size() > 0) ? src_q[0] : '0;
        m_axi_bvalid  = b_en && (b_q.size() > 0) && ($urandom_range(0, 3) != 0);
        m_axi_bresp   = (b_q.size() > 0) ? b_q[0] : 2'b00;
        #1;
        if (m_axi_wvalid && m_axi_wready) begin
          check("w_after_aw", DW'(aw_q.size() > 0), DW'(1));
          if (aw_q.size() > 0) begin
            check("wlast", DW'(m_axi_wlast), DW'(wbeat == int'(aw_q[0].len)));
            mem[aw_q[0].addr + 32'(wbeat * BYTES)] = m_axi_wdata;
            if (m_axi_wlast) wlast_cnt++;
            if (wbeat == int'(aw_q[0].len)) begin
              b_q.push_back((burst_no == err_burst) ? 2'b10 : 2'b00);
              burst_no++;
              wbeat = 0;
              void'(aw_q.pop_front());
            end else begin
              wbeat++;
            end
          end
        end
        if (s_data_valid && s_data_ready) void'(src_q.pop_front());
        if (m_axi_awvalid && m_axi_awready) begin
          aw_log.push_back('{m_axi_awaddr, m_axi_awlen});
          aw_q.push_back('{m_axi_awaddr, m_axi_awlen});
        end
        if (m_axi_bvalid && m_axi_bready) begin
          void'(b_q.pop_front());
          last_b_cyc = cyc;
        end
      end
    end
  end

  task automatic send_cmd(input logic [31:0] a, input int beats);
    int t;
    @(negedge clk);
    cmd_valid = 1; cmd_addr = a; cmd_beats = LW'(beats);
    #1;
    t = 0;
    while (!cmd_ready && t < 100) begin
      @(negedge clk); #1; t++;
    end
    check("cmd_accept", DW'(cmd_ready), DW'(1));
    @(negedge clk);
    cmd_valid = 0;
  endtask

  task automatic start_xfer(input logic [31:0] a, input int beats, input bit aw_al,
                            input bit wr, input bit b_on, input int eb);
    logic [31:0] am;
    int rem, room, n;
    logic [DW-1:0] d;
    exp_q.delete(); exp_data.delete(); aw_log.delete(); mem.delete(); src_q.delete();
    am = a & ~32'(BYTES - 1);
    exp_base = am;
    rem = beats;
    while (rem > 0) begin
      room = (4096 - int'(am % 4096)) / BYTES;
      n = rem;
      if (n > 64) n = 64;
      if (n > room) n = room;
      exp_q.push_back('{am, 8'(n - 1)});
      am += 32'(n * BYTES);
      rem -= n;
    end
    for (int i = 0; i < beats; i++) begin
      for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = $urandom;
      exp_data.push_back(d);
      src_q.push_back(d);
    end
    wlast_cnt = 0; burst_no = 0; wbeat = 0; err_burst = eb;
    aw_always = aw_al; w_rand = wr; b_en = b_on;
    send_cmd(a, beats);
  endtask

  task automatic finish_xfer(input logic exp_err, input string nm);
    bit got;
    int n;
    logic [31:0] a;
    got = 0;
    for (int t = 0; t < 20000; t++) begin
      @(negedge clk); #2;
      if (done === 1'b1) begin got = 1; break; end
    end
    check({nm, "_done"}, DW'(got), DW'(1));
    if (got) begin
      check({nm, "_err"}, DW'(err), DW'(exp_err));
      check({nm, "_done_latency"}, DW'(cyc), DW'(last_b_cyc + 1));
      check({nm, "_aw_count"}, DW'(aw_log.size()), DW'(exp_q.size()));
      n = (aw_log.size() < exp_q.size()) ? aw_log.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
        check({nm, "_awaddr"}, DW'(aw_log[i].addr), DW'(exp_q[i].addr));
        check({nm, "_awlen"}, DW'(aw_log[i].len), DW'(exp_q[i].len));
      end
      check({nm, "_wlast_count"}, DW'(wlast_cnt), DW'(exp_q.size()));
      for (int i = 0; i < exp_data.size(); i++) begin
        a = exp_base + 32'(i * BYTES);
        check({nm, "_ddr_data"}, mem.exists(a) ? mem[a] : {DW{1'bx}}, exp_data[i]);
      end
      @(negedge clk); #2;
      check({nm, "_done_pulse"}, DW'(done), DW'(0));
      check({nm, "_idle_ready"}, DW'(cmd_ready), DW'(1));
    end
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: time limit reached, %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    cmd_valid = 0; cmd_addr = '0; cmd_beats = '0;

    // Reset values and constant outputs.
    repeat (3) @(negedge clk);
    #1;
    check("rst_cmd_ready", DW'(cmd_ready), DW'(0));
    check("rst_busy", DW'(busy), DW'(0));
    check("rst_awvalid", DW'(m_axi_awvalid), DW'(0));
    check("rst_wvalid", DW'(m_axi_wvalid), DW'(0));
    check("rst_wlast", DW'(m_axi_wlast), DW'(0));
    check("rst_done", DW'(done), DW'(0));
    check("rst_err", DW'(err), DW'(0));
    check("rst_bready", DW'(m_axi_bready), DW'(0));
    check("rst_awaddr", DW'(m_axi_awaddr), DW'(0));
    #2 reset = 0;
    #1 check("ready_before_edge", DW'(cmd_ready), DW'(0));
    @(negedge clk); #2;
    check("ready_after_reset", DW'(cmd_ready), DW'(1));
    check("awid", DW'(m_axi_awid), DW'(0));
    check("awsize", DW'(m_axi_awsize), DW'(6));
    check("awburst", DW'(m_axi_awburst), DW'(1));
    check("awlock", DW'(m_axi_awlock), DW'(0));
    check("awcache", DW'(m_axi_awcache), DW'(3));
    check("awprot", DW'(m_axi_awprot), DW'(0));
    check("awqos", DW'(m_axi_awqos), DW'(0));
    check("wstrb", DW'(m_axi_wstrb), {DW{1'b0}} | {(DW/8){1'b1}});

    // Single beat.
    start_xfer(32'h100, 1, 0, 0, 1, -1);
    finish_xfer(0, "single");

    // Multi-burst, 200 beats from 0.
    start_xfer(32'h0, 200, 0, 0, 1, -1);
    finish_xfer(0, "multi");

    // 4 KB split.
    start_xfer(32'hFC0, 4, 1, 0, 1, -1);
    finish_xfer(0, "split4k");

    // Outstanding limit with B withheld.
    start_xfer(32'h0, 512, 1, 1, 0, -1);
    repeat (2000) @(negedge clk);
    #2;
    check("bp_aw_count", DW'(aw_log.size()), DW'(4));
    check("bp_wlast_count", DW'(wlast_cnt), DW'(4));
    check("bp_busy", DW'(busy), DW'(1));
    b_en = 1;
    finish_xfer(0, "bp");

    // Error response on burst 2 of 3, then a clean command.
    start_xfer(32'h2000, 150, 0, 1, 1, 1);
    finish_xfer(1, "bresp_err");
    start_xfer(32'h2000, 150, 0, 1, 1, -1);
    finish_xfer(0, "after_err");

    // Zero length.
    start_xfer(32'h40, 0, 0, 0, 1, -1);
    #2;
    check("zero_done", DW'(done), DW'(1));
    check("zero_awvalid", DW'(m_axi_awvalid), DW'(0));
    @(negedge clk); #2;
    check("zero_done_pulse", DW'(done), DW'(0));
    check("zero_no_aw", DW'(aw_log.size()), DW'(0));

    // Randomised transfers with random handshakes and unaligned start addresses.
    for (int r = 0; r < 3; r++) begin
      start_xfer($urandom & 32'h003F_FFFF, int'($urandom_range(1, 300)), 0, 1, 1, -1);
      finish_xfer(0, "rand");
    end

    // Reset in the middle of a transfer.
    start_xfer(32'h800, 300, 0, 1, 1, -1);
    t = 0;
    while (aw_log.size() < 2 && t < 2000) begin
      @(negedge clk); t++;
    end
    check("mid_aw_seen", DW'(aw_log.size() >= 2), DW'(1));
    @(negedge clk);
    #3 reset = 1;
    #1;
    check("mid_rst_awvalid", DW'(m_axi_awvalid), DW'(0));
    check("mid_rst_wvalid", DW'(m_axi_wvalid), DW'(0));
    check("mid_rst_busy", DW'(busy), DW'(0));
    check("mid_rst_cmd_ready", DW'(cmd_ready), DW'(0));
    check("mid_rst_bready", DW'(m_axi_bready), DW'(0));
    repeat (2) @(negedge clk);
    #3 reset = 0;
    src_q.delete(); aw_q.delete(); b_q.delete(); wbeat = 0;
    #1 check("mid_ready_before_edge", DW'(cmd_ready), DW'(0));
    @(negedge clk); #2;
    check("mid_ready_after", DW'(cmd_ready), DW'(1));
    check("mid_busy_after", DW'(busy), DW'(0));
    start_xfer(32'hFC0, 70, 0, 1, 1, -1);
    finish_xfer(0, "post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
